// File: rtl/gauss_edge_feeder.sv
// rtl/gauss_edge_feeder.sv - skewed top-edge row feeder for the Gaussian-elimination array; GAUSS_FEEDER_ZERO_ROW_FLAG_EN adds zero_row
module gauss_edge_feeder #(
  parameter int GF_BIT       = 4,
  parameter int OP_CODE_LEN  = 4,
  parameter int NUM_PROC_COL = 3,
  parameter int NUM_ROWS     = 4
) (
  input  logic                             clk,
  input  logic                             rst,
  input  logic                             in_valid,
  output logic                             in_ready,
  input  logic [NUM_PROC_COL*GF_BIT-1:0]   in_row,
  input  logic [OP_CODE_LEN-1:0]           in_op,
  output logic [NUM_PROC_COL-1:0]          start_out,
  output logic [NUM_PROC_COL-1:0]          finish_out,
  output logic [NUM_PROC_COL*OP_CODE_LEN-1:0] op_out,
  output logic [NUM_PROC_COL*GF_BIT-1:0]   data_out,
  output logic                             busy,
`ifdef GAUSS_FEEDER_ZERO_ROW_FLAG_EN
  output logic                             zero_row,
`endif
  output logic                             done
);

  localparam int RW = $clog2(NUM_ROWS + 1);
  localparam int FW = $clog2(NUM_PROC_COL + 1);

  localparam logic [1:0] S_IDLE  = 2'd0;
  localparam logic [1:0] S_FEED  = 2'd1;
  localparam logic [1:0] S_FLUSH = 2'd2;

  logic [1:0]             state;
  logic [RW-1:0]          row_cnt;
  logic [FW-1:0]          flush_cnt;
  logic [OP_CODE_LEN-1:0] op_lat;
  logic                   accept;
  logic                   first_row;
  logic                   last_row;
  logic [OP_CODE_LEN-1:0] cur_op;

  // Control pipeline shared by all lanes: stage d drives lane d's tags and op.
  logic [OP_CODE_LEN-1:0] op_stg [NUM_PROC_COL];
  logic [NUM_PROC_COL-1:0] st_stg;
  logic [NUM_PROC_COL-1:0] fin_stg;

  // Ready is held low during reset so no row slips in on the reset edge.
  assign in_ready  = !rst && (state == S_IDLE || state == S_FEED);
  assign accept    = in_valid && in_ready;
  assign first_row = (state == S_IDLE);
  assign last_row  = first_row ? (NUM_ROWS == 1) : (row_cnt == RW'(NUM_ROWS - 1));
  // The first row of a matrix uses the live op; later rows use the latched one.
  assign cur_op    = first_row ? in_op : op_lat;
  assign busy      = (state != S_IDLE);
  assign start_out  = st_stg;
  assign finish_out = fin_stg;

  // Matrix sequencing: row counting, op latch, flush countdown and done pulse.
  always_ff @(posedge clk) begin
    if (rst) begin
      state     <= S_IDLE;
      row_cnt   <= '0;
      flush_cnt <= '0;
      op_lat    <= '0;
      done      <= 1'b0;
    end else begin
      done <= 1'b0;
      case (state)
        S_IDLE, S_FEED: begin
          if (accept) begin
            if (first_row) op_lat <= in_op;
            if (last_row) begin
              state     <= S_FLUSH;
              row_cnt   <= '0;
              flush_cnt <= '0;
            end else begin
              state   <= S_FEED;
              row_cnt <= first_row ? RW'(1) : row_cnt + RW'(1);
            end
          end
        end
        S_FLUSH: begin
          if (flush_cnt == FW'(NUM_PROC_COL - 1)) begin
            state     <= S_IDLE;
            flush_cnt <= '0;
            done      <= 1'b1;
          end else begin
            flush_cnt <= flush_cnt + FW'(1);
          end
        end
        default: state <= S_IDLE;
      endcase
    end
  end

  // Shift op/start/finish down the skew pipeline; idle cycles inject a NOP bubble.
  always_ff @(posedge clk) begin
    if (rst) begin
      for (int d = 0; d < NUM_PROC_COL; d++) op_stg[d] <= '0;
      st_stg  <= '0;
      fin_stg <= '0;
    end else begin
      op_stg[0]  <= accept ? cur_op : '0;
      st_stg[0]  <= accept && first_row;
      fin_stg[0] <= accept && last_row;
      for (int d = 1; d < NUM_PROC_COL; d++) begin
        op_stg[d]  <= op_stg[d-1];
        st_stg[d]  <= st_stg[d-1];
        fin_stg[d] <= fin_stg[d-1];
      end
    end
  end

  for (genvar j = 0; j < NUM_PROC_COL; j++) begin : g_lane
    logic [GF_BIT-1:0] chain [0:j];

    // Element j enters with element 0 and rides a (j+1)-deep chain to its lane.
    always_ff @(posedge clk) begin
      if (rst) begin
        for (int d = 0; d <= j; d++) chain[d] <= '0;
      end else begin
        chain[0] <= accept ? in_row[j*GF_BIT +: GF_BIT] : '0;
        for (int d = 1; d <= j; d++) chain[d] <= chain[d-1];
      end
    end

    assign data_out[j*GF_BIT +: GF_BIT]        = chain[j];
    assign op_out[j*OP_CODE_LEN +: OP_CODE_LEN] = op_stg[j];
  end

`ifdef GAUSS_FEEDER_ZERO_ROW_FLAG_EN
  // Sticky all-zero-row flag, re-armed by the first row of each matrix.
  always_ff @(posedge clk) begin
    if (rst) begin
      zero_row <= 1'b0;
    end else if (accept) begin
      if (first_row)          zero_row <= (in_row == '0);
      else if (in_row == '0)  zero_row <= 1'b1;
    end
  end
`endif

endmodule

// File: tb/tb_gauss_edge_feeder.sv
// tb/tb_gauss_edge_feeder.sv - scoreboard bench for gauss_edge_feeder
module tb_gauss_edge_feeder;

  localparam int NPC = 3;
  localparam int NR  = 4;

  typedef struct packed {
    logic [11:0] row;
    logic [3:0]  op;
    logic        st;
    logic        fin;
  } ent_t;

  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic        in_valid = 1'b0;
  logic [11:0] in_row = '0;
  logic [3:0]  in_op = '0;
  logic        in_ready, busy, done;
  logic [2:0]  start_out, finish_out;
  logic [11:0] op_out, data_out;

  logic        in_valid1 = 1'b0;
  logic [11:0] in_row1 = '0;
  logic [3:0]  in_op1 = '0;
  logic        in_ready1, busy1, done1;
  logic [2:0]  start_out1, finish_out1;
  logic [11:0] op_out1, data_out1;

`ifdef GAUSS_FEEDER_ZERO_ROW_FLAG_EN
  logic zero_row, zero_row1;
`endif

  int   n_assert = 0;
  int   n_fail   = 0;
  ent_t exp_q[$];
  int   m_rows = 0;
  int   m_flush_left = -1;
  logic m_busy = 1'b0;
  logic m_done = 1'b0;
  logic m_zr   = 1'b0;
  logic [3:0] m_op = '0;

  always #5 clk = ~clk;

  gauss_edge_feeder #(.GF_BIT(4), .OP_CODE_LEN(4), .NUM_PROC_COL(NPC), .NUM_ROWS(NR)) dut (
    .clk(clk), .rst(rst), .in_valid(in_valid), .in_ready(in_ready), .in_row(in_row),
    .in_op(in_op), .start_out(start_out), .finish_out(finish_out), .op_out(op_out),
    .data_out(data_out), .busy(busy),
`ifdef GAUSS_FEEDER_ZERO_ROW_FLAG_EN
    .zero_row(zero_row),
`endif
    .done(done));

  gauss_edge_feeder #(.GF_BIT(4), .OP_CODE_LEN(4), .NUM_PROC_COL(NPC), .NUM_ROWS(1)) dut1 (
    .clk(clk), .rst(rst), .in_valid(in_valid1), .in_ready(in_ready1), .in_row(in_row1),
    .in_op(in_op1), .start_out(start_out1), .finish_out(finish_out1), .op_out(op_out1),
    .data_out(data_out1), .busy(busy1),
`ifdef GAUSS_FEEDER_ZERO_ROW_FLAG_EN
    .zero_row(zero_row1),
`endif
    .done(done1));

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] expv);
    n_assert++;
    assert (obs === expv) else begin
      n_fail++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, expv);
    end
  endtask

  task automatic clear_model();
    exp_q.delete();
    for (int i = 0; i < NPC; i++) exp_q.push_back('0);
    m_rows = 0; m_flush_left = -1; m_busy = 1'b0; m_done = 1'b0; m_zr = 1'b0; m_op = '0;
  endtask

  // One clock of stimulus for the main DUT; expected lane-0 entry pushed, lanes checked from queue.
  task automatic tick(input logic v, input logic [11:0] row, input logic [3:0] op, input logic r);
    logic rdy, acc, first, last;
    ent_t e;
    logic [11:0] er;
    rst = r; in_valid = v; in_row = row; in_op = op;
    rdy = !r && !(m_busy && m_rows == NR);
    acc = v && rdy;
    @(posedge clk);
    if (r) begin
      clear_model();
    end else begin
      m_done = 1'b0;
      if (m_flush_left > 0) begin
        m_flush_left--;
        if (m_flush_left == 0) begin m_done = 1'b1; m_busy = 1'b0; m_rows = 0; end
      end
      if (acc) begin
        first = (m_rows == 0);
        if (first) m_op = op;
        m_rows++;
        last = (m_rows == NR);
        if (last) m_flush_left = NPC;
        m_busy = 1'b1;
        exp_q.push_back('{row: row, op: m_op, st: first, fin: last});
        if (first) m_zr = (row == 12'h000);
        else if (row == 12'h000) m_zr = 1'b1;
      end else begin
        exp_q.push_back('0);
      end
      while (exp_q.size() > NPC) void'(exp_q.pop_front());
    end
    @(negedge clk);
    chk("in_ready", in_ready, !r && !(m_busy && m_rows == NR));
    chk("busy", busy, m_busy);
    chk("done", done, m_done);
`ifdef GAUSS_FEEDER_ZERO_ROW_FLAG_EN
    chk("zero_row", zero_row, m_zr);
`endif
    for (int j = 0; j < NPC; j++) begin
      e  = exp_q[exp_q.size() - 1 - j];
      er = e.row;
      chk($sformatf("lane%0d_data", j), data_out[j*4 +: 4], er[j*4 +: 4]);
      chk($sformatf("lane%0d_op", j), op_out[j*4 +: 4], e.op);
      chk($sformatf("lane%0d_start", j), start_out[j], e.st);
      chk($sformatf("lane%0d_finish", j), finish_out[j], e.fin);
    end
  endtask

  task automatic idle(input int n);
    for (int i = 0; i < n; i++) tick(1'b0, 12'h000, 4'h0, 1'b0);
  endtask

  // Directed step for the single-row instance.
  task automatic step1(input logic v, input string tag, input logic [11:0] ed, input logic [11:0] eo,
                       input logic [2:0] es, input logic rdy, input logic bsy, input logic dn);
    in_valid1 = v; in_row1 = 12'h5A3; in_op1 = 4'h2;
    @(posedge clk);
    @(negedge clk);
    in_valid1 = 1'b0;
    chk({tag, "_data"}, data_out1, ed);
    chk({tag, "_op"}, op_out1, eo);
    chk({tag, "_start"}, start_out1, es);
    chk({tag, "_finish"}, finish_out1, es);
    chk({tag, "_ready"}, in_ready1, rdy);
    chk({tag, "_busy"}, busy1, bsy);
    chk({tag, "_done"}, done1, dn);
  endtask

  initial begin
    logic [11:0] rows_a [4];
    logic [11:0] rows_z [4];
    rows_a = '{12'h321, 12'h654, 12'h987, 12'hCBA};
    rows_z = '{12'h321, 12'h000, 12'h987, 12'hCBA};
    clear_model();

    tick(1'b0, 12'h000, 4'h0, 1'b1);
    tick(1'b1, 12'h321, 4'h1, 1'b1);
    idle(1);

    // Back-to-back matrix.
    for (int i = 0; i < 4; i++) tick(1'b1, rows_a[i], 4'h1, 1'b0);
    idle(5);

    // Two bubbles after row 2.
    for (int i = 0; i < 2; i++) tick(1'b1, rows_a[i], 4'h1, 1'b0);
    idle(2);
    for (int i = 2; i < 4; i++) tick(1'b1, rows_a[i], 4'h1, 1'b0);
    idle(6);

    // Op change mid-matrix, valid held high so the next matrix starts on the done cycle.
    tick(1'b1, rows_a[0], 4'h1, 1'b0);
    for (int i = 1; i < 12; i++) tick(1'b1, rows_a[i % 4], 4'h6, 1'b0);
    idle(6);

    // Reset after two rows, then a clean matrix.
    tick(1'b1, rows_a[0], 4'h1, 1'b0);
    tick(1'b1, rows_a[1], 4'h1, 1'b0);
    tick(1'b0, 12'h000, 4'h0, 1'b1);
    idle(2);
    for (int i = 0; i < 4; i++) tick(1'b1, rows_a[i], 4'h1, 1'b0);
    idle(5);

    // Zero rows mid-matrix, then a non-zero first row.
    for (int i = 0; i < 4; i++) tick(1'b1, rows_z[i], 4'h3, 1'b0);
    idle(5);
    for (int i = 0; i < 4; i++) tick(1'b1, rows_a[i], 4'h4, 1'b0);
    idle(5);

    // Random traffic.
    for (int i = 0; i < 40; i++)
      tick(1'($urandom_range(0, 1)), 12'($urandom_range(0, 4095)), 4'($urandom_range(0, 15)), 1'b0);
    idle(8);

    // Single-row matrices.
    step1(1'b1, "r1_lane0", 12'h003, 12'h002, 3'b001, 1'b0, 1'b1, 1'b0);
    step1(1'b0, "r1_lane1", 12'h0A0, 12'h020, 3'b010, 1'b0, 1'b1, 1'b0);
    step1(1'b0, "r1_lane2", 12'h500, 12'h200, 3'b100, 1'b0, 1'b1, 1'b0);
    step1(1'b0, "r1_done",  12'h000, 12'h000, 3'b000, 1'b1, 1'b0, 1'b1);
    step1(1'b0, "r1_after", 12'h000, 12'h000, 3'b000, 1'b1, 1'b0, 1'b0);

    $display("End of test - %0d assertions evaluated, %0d failures", n_assert, n_fail);
    $finish;
  end

endmodule

// File: doc/gauss_edge_feeder.md
# gauss_edge_feeder

Injection-side driver for the systolic Gaussian-elimination processor array. Accepts matrix rows over a valid/ready stream and drives the array's top edge, one lane per processor column. Each lane carries data, op code and start/finish row tags, with the diagonal skew the array expects. Its downstream peers are the array processors that consume `start_in`, `finish_in`, `op_in` and `data_in`.

## Interface
- `GF_BIT`, 4: field element width (4 = GF(16), 8 = GF(256)).
- `OP_CODE_LEN`, 4: op-code width.
- `NUM_PROC_COL`, 3: array columns / output lanes (≥1).
- `NUM_ROWS`, 4: rows per matrix (≥1).
- `clk`  in  1  single clock, all logic on rising edge.
- `rst`  in  1  synchronous, active-high reset.
- `in_valid`  in  1  row present.
- `in_ready`  out  1  feeder accepts row this cycle.
- `in_row`  in  NUM_PROC_COL*GF_BIT  row elements; element j at bits [j*GF_BIT +: GF_BIT].
- `in_op`  in  OP_CODE_LEN  op code, sampled only with the first row of a matrix.
- `start_out`  out  NUM_PROC_COL  per-lane first-row tag.
- `finish_out`  out  NUM_PROC_COL  per-lane last-row tag.
- `op_out`  out  NUM_PROC_COL*OP_CODE_LEN  per-lane op code.
- `data_out`  out  NUM_PROC_COL*GF_BIT  per-lane element.
- `busy`  out  1  matrix in progress (state ≠ IDLE).
- `done`  out  1  one-cycle pulse when the last skewed element has left lane NUM_PROC_COL-1.

## Operation
- A row is accepted on an edge where `in_valid && in_ready`.
- FSM states:
  - IDLE: `in_ready`=1. Accepting a row latches `in_op`, sets row_cnt=1, tags the row start. Next state is FEED, or FLUSH if NUM_ROWS==1.
  - FEED: `in_ready`=1. Each accept increments row_cnt. The accept with row_cnt==NUM_ROWS-1 is tagged finish and goes to FLUSH.
  - FLUSH: `in_ready`=0. flush_cnt counts NUM_PROC_COL cycles, then `done` pulses and the state returns to IDLE. `done` pulses on the edge that enters IDLE.
- NUM_ROWS==1: the single row carries both start and finish.
- Lane 0 stage register, per accepted row: data = element 0, op = latched op, start/finish = tags.
- Lane 0 stage register, non-accept cycles (bubble): data=0, op=0 (NOP), start=0, finish=0.
- Lane j gets a j-deep shift chain, so element j of a row appears j cycles after element 0. Bubbles skew identically.
- Elements 1..NUM_PROC_COL-1 enter their chains in the same cycle as element 0.
- The op code is constant for the whole matrix. A new `in_op` is ignored until IDLE.
- row_cnt width is clog2(NUM_ROWS+1). flush_cnt width is clog2(NUM_PROC_COL+1). Neither wraps: each is cleared on entry to FEED/FLUSH.
- Reset, including mid-matrix: all lane registers are 0, state=IDLE, counters=0, latched op=0. In-flight rows are discarded and no `done` pulse is produced.
- Reset values of outputs: `in_ready`=0 while `rst` is high, then 1. `busy`=0, `done`=0, all `start_out`/`finish_out`/`op_out`/`data_out` bits 0.

## Timing
- Accept at edge k: lane 0 outputs are valid after edge k+1; lane j outputs are valid after edge k+1+j.
- Back-to-back accepts give one row per cycle; there are no internal stalls.
- `in_valid` low in FEED inserts exactly one bubble per idle cycle.
- The last row is accepted at edge k. Lane NUM_PROC_COL-1 holds it after edge k+NUM_PROC_COL, and `done` is high in the cycle after edge k+NUM_PROC_COL.
- Earliest next-matrix accept is the edge where `done` is high (IDLE, `in_ready`=1). Its lane 0 output overlaps the drain of nothing, because all chains are empty.
- All outputs are registered; no combinational path runs from `in_*` to lane outputs. `in_ready` depends on state only.

## Configuration
- `GAUSS_FEEDER_ZERO_ROW_FLAG_EN` defined:
  - Adds output `zero_row` (1 bit, reset 0).
  - It is a sticky flag, set on any accepted row whose elements are all 0.
  - It is cleared on the first-row accept of the next matrix; if that row is itself all-zero, the flag is set instead.
  - It stays readable after `done`.
- Undefined: the port and its logic are absent, and the remaining behaviour is identical.

## Test plan
- Defaults, 4 back-to-back rows 0x321, 0x654, 0x987, 0xCBA, `in_op`=1:
  - lane0 data is 1,4,7,A on edges k+1..k+4 and lane2 data is 3,6,9,C on edges k+3..k+6.
  - start only with the first row and finish only with the last row, on every lane.
  - `done` is high in the cycle after edge k+3+3.
- Same matrix with `in_valid` low for 2 cycles after row 2: lane0 shows data 0, op 0 for exactly 2 cycles between 4 and 7. Skew is preserved on lanes 1 and 2, and `done` is delayed by 2.
- NUM_ROWS=1: a single row 0x5A3 carries start=finish=1 on all lanes. `in_ready` drops the next cycle, `done` follows NUM_PROC_COL cycles later, and `busy` falls with `done`.
- `in_op` changes 1→6 mid-matrix: all lanes keep op 1. After `done`, a new matrix with `in_op`=6 shows op 6.
- Assert `rst` for 1 cycle after 2 rows: the next cycle all outputs are 0, `busy`=0, `in_ready`=1, no `done` pulse. A full matrix afterwards behaves as in the first scenario.
- With `GAUSS_FEEDER_ZERO_ROW_FLAG_EN`, rows 0x321, 0x000, 0x987, 0xCBA: `zero_row` rises the cycle after row 2 is accepted and holds. The next matrix's non-zero first row clears it.
